// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// pipeline_hazard_controller: stall/flush arbitration, memory-wait watchdog FSM, saturating perf counters.
// Rev 1.0
module pipeline_hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PERF_CNT_WIDTH = 32,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      exValid,
  input  logic                      exIsBranch,
  input  logic                      exBranchTaken,
  input  logic                      exBranchPredicted,
  input  logic                      exIsLoad,
  input  logic                      exRdWriteEnable,
  input  logic [REG_ADDR_WIDTH-1:0] exRdAddr,
  input  logic                      idValid,
  input  logic                      idRs1Used,
  input  logic                      idRs2Used,
  input  logic [REG_ADDR_WIDTH-1:0] idRs1Addr,
  input  logic [REG_ADDR_WIDTH-1:0] idRs2Addr,
  input  logic                      memReq,
  input  logic                      memReady,
  output logic                      ifStall,
  output logic                      idStall,
  output logic                      exStall,
  output logic                      idFlush,
  output logic                      exFlush,
  output logic [1:0]                ctrlState,
  output logic                      memTimeout,
  output logic [PERF_CNT_WIDTH-1:0] perfStallCycles,
  output logic [PERF_CNT_WIDTH-1:0] perfMispredicts,
  output logic [PERF_CNT_WIDTH-1:0] perfLoadUse
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [7:0] C_WAIT_LIMIT = 8'(TIMEOUT - 1);
  localparam logic [PERF_CNT_WIDTH-1:0] C_CNT_MAX = '1;

  state_e                    state_q, state_d;
  logic [7:0]                wait_cnt_q, wait_cnt_d;
  logic [PERF_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [PERF_CNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d;

  logic w_mem_wait;
  logic w_stall_all;
  logic w_mispredict;
  logic w_load_use;
  logic w_act_flush;
  logic w_act_lu;

  assign w_mem_wait   = memReq & ~memReady;
  assign w_stall_all  = w_mem_wait | (state_q == ST_ERROR);
  assign w_mispredict = exValid & exIsBranch & (exBranchTaken != exBranchPredicted);
  assign w_load_use   = exValid & exIsLoad & exRdWriteEnable & (exRdAddr != '0) & idValid &
                        ((idRs1Used & (idRs1Addr == exRdAddr)) |
                         (idRs2Used & (idRs2Addr == exRdAddr)));

  // Priority chain: a memory stall masks everything, a mispredict masks load-use.
  assign w_act_flush = ~w_stall_all & w_mispredict;
  assign w_act_lu    = ~w_stall_all & ~w_mispredict & w_load_use;

  always_comb begin
    ifStall = 1'b0;
    idStall = 1'b0;
    exStall = 1'b0;
    idFlush = 1'b0;
    exFlush = 1'b0;
    // Outputs are forced quiet while reset is held, whatever the inputs do.
    if (rst) begin
      if (w_stall_all) begin
        ifStall = 1'b1;
        idStall = 1'b1;
        exStall = 1'b1;
      end else if (w_act_flush) begin
        idFlush = 1'b1;
        exFlush = 1'b1;
      end else if (w_act_lu) begin
        ifStall = 1'b1;
        idStall = 1'b1;
        exFlush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 8'd0;
    if (w_mem_wait && (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else if (w_mem_wait) begin
      wait_cnt_d = wait_cnt_q;
    end
    case (state_q)
      ST_RUN: begin
        if (w_mem_wait && (wait_cnt_q == C_WAIT_LIMIT)) state_d = ST_ERROR;
        else if (w_mem_wait)                             state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (w_mem_wait && (wait_cnt_q == C_WAIT_LIMIT)) state_d = ST_ERROR;
        else if (!w_mem_wait)                            state_d = ST_RUN;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    lu_cnt_d      = lu_cnt_q;
    if ((w_stall_all || w_act_lu) && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (w_act_flush && (mispred_cnt_q != C_CNT_MAX)) begin
      mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
    if (w_act_lu && (lu_cnt_q != C_CNT_MAX)) begin
      lu_cnt_d = lu_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 8'd0;
      stall_cnt_q   <= '0;
      mispred_cnt_q <= '0;
      lu_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      lu_cnt_q      <= lu_cnt_d;
    end
  end

  assign ctrlState       = state_q;
  assign memTimeout      = (state_q == ST_ERROR);
  assign perfStallCycles = stall_cnt_q;
  assign perfMispredicts = mispred_cnt_q;
  assign perfLoadUse     = lu_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// tb_pipeline_hazard_controller: directed scenarios plus randomized traffic against a behavioural model.
// Rev 1.0
module tb_pipeline_hazard_controller;

  localparam int RAW = 5;
  localparam int PCW = 4;
  localparam int TMO = 4;
  localparam int CMAX = (1 << PCW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           exValid, exIsBranch, exBranchTaken, exBranchPredicted;
  logic           exIsLoad, exRdWriteEnable;
  logic [RAW-1:0] exRdAddr, idRs1Addr, idRs2Addr;
  logic           idValid, idRs1Used, idRs2Used;
  logic           memReq, memReady;
  logic           ifStall, idStall, exStall, idFlush, exFlush;
  logic [1:0]     ctrlState;
  logic           memTimeout;
  logic [PCW-1:0] perfStallCycles, perfMispredicts, perfLoadUse;

  int total = 0;
  int bad   = 0;

  // Model: sticky error flag, previous-cycle wait flag, length of the current run of wait cycles.
  bit m_err, m_prev_wait;
  int m_run, m_stall, m_mis, m_lu;

  pipeline_hazard_controller #(
    .REG_ADDR_WIDTH(RAW), .PERF_CNT_WIDTH(PCW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .exValid(exValid), .exIsBranch(exIsBranch), .exBranchTaken(exBranchTaken),
    .exBranchPredicted(exBranchPredicted), .exIsLoad(exIsLoad),
    .exRdWriteEnable(exRdWriteEnable), .exRdAddr(exRdAddr),
    .idValid(idValid), .idRs1Used(idRs1Used), .idRs2Used(idRs2Used),
    .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr),
    .memReq(memReq), .memReady(memReady),
    .ifStall(ifStall), .idStall(idStall), .exStall(exStall),
    .idFlush(idFlush), .exFlush(exFlush), .ctrlState(ctrlState),
    .memTimeout(memTimeout), .perfStallCycles(perfStallCycles),
    .perfMispredicts(perfMispredicts), .perfLoadUse(perfLoadUse)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ctrl_obs();
    return {ifStall, idStall, exStall, idFlush, exFlush};
  endfunction

  function automatic bit mdl_wait();
    return memReq && !memReady;
  endfunction

  function automatic bit mdl_mis();
    return exValid && exIsBranch && (exBranchTaken != exBranchPredicted);
  endfunction

  function automatic bit mdl_lu();
    bit hit1, hit2;
    hit1 = idRs1Used && (idRs1Addr == exRdAddr);
    hit2 = idRs2Used && (idRs2Addr == exRdAddr);
    return exValid && exIsLoad && exRdWriteEnable && (exRdAddr != 0) && idValid && (hit1 || hit2);
  endfunction

  // Expected {ifStall,idStall,exStall,idFlush,exFlush} for the present inputs.
  function automatic logic [4:0] mdl_ctrl();
    if (mdl_wait() || m_err) return 5'b11100;
    if (mdl_mis())           return 5'b00011;
    if (mdl_lu())            return 5'b11001;
    return 5'b00000;
  endfunction

  function automatic logic [1:0] mdl_state();
    if (m_err)       return 2'd2;
    if (m_prev_wait) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_clear();
    m_err = 0; m_prev_wait = 0; m_run = 0; m_stall = 0; m_mis = 0; m_lu = 0;
  endtask

  task automatic model_edge();
    bit w, stall_all, mis, lu;
    w         = mdl_wait();
    stall_all = w || m_err;
    mis       = mdl_mis();
    lu        = mdl_lu();
    m_run     = w ? m_run + 1 : 0;
    if (w && m_run >= TMO) m_err = 1;
    m_prev_wait = w;
    if (stall_all || (!mis && lu))        m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    if (!stall_all && mis)                m_mis   = (m_mis   < CMAX) ? m_mis + 1   : CMAX;
    if (!stall_all && !mis && lu)         m_lu    = (m_lu    < CMAX) ? m_lu + 1    : CMAX;
  endtask

  task automatic clear_inputs();
    exValid = 0; exIsBranch = 0; exBranchTaken = 0; exBranchPredicted = 0;
    exIsLoad = 0; exRdWriteEnable = 0; exRdAddr = '0;
    idValid = 0; idRs1Used = 0; idRs2Used = 0; idRs1Addr = '0; idRs2Addr = '0;
    memReq = 0; memReady = 0;
  endtask

  task automatic set_load_use(input logic [RAW-1:0] addr);
    exValid = 1; exIsLoad = 1; exRdWriteEnable = 1; exRdAddr = addr;
    idValid = 1; idRs2Used = 1; idRs2Addr = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    model_clear();
    @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      memReq = 1'($urandom); memReady = 1'($urandom);
      set_load_use(5'd7);
      exIsBranch = 1; exBranchTaken = 1'($urandom); exBranchPredicted = 1'($urandom);
      @(posedge clk);
      #2;
      total++;
      if (ctrl_obs() !== 5'b0 || ctrlState !== 2'd0 || memTimeout !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: ctrl=%b state=%0d tmo=%b, required ctrl=00000 state=0 tmo=0",
                 ctrl_obs(), ctrlState, memTimeout);
      end
      total++;
      if (perfStallCycles !== '0 || perfMispredicts !== '0 || perfLoadUse !== '0) begin
        bad++;
        $display("FAIL reset_counters: stall=%0d mis=%0d lu=%0d, required 0 0 0",
                 perfStallCycles, perfMispredicts, perfLoadUse);
      end
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    #1;
    total++;
    if (ctrl_obs() !== 5'b11001) begin
      bad++; $display("FAIL load_use_ctrl: got %b, required 11001", ctrl_obs());
    end
    tick();
    total++;
    if (perfLoadUse !== 4'd1) begin
      bad++; $display("FAIL load_use_count: got %0d, required 1", perfLoadUse);
    end
    exRdAddr = '0; idRs2Addr = '0;
    #1;
    total++;
    if (ctrl_obs() !== 5'b00000) begin
      bad++; $display("FAIL load_use_x0: got %b, required 00000", ctrl_obs());
    end
    tick();
    total++;
    if (perfLoadUse !== 4'd1 || perfStallCycles !== 4'd1) begin
      bad++; $display("FAIL load_use_x0_count: lu=%0d stall=%0d, required 1 1", perfLoadUse, perfStallCycles);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_load_use(5'd5);
    exIsBranch = 1; exBranchTaken = 1; exBranchPredicted = 0;
    #1;
    total++;
    if (ctrl_obs() !== 5'b00011) begin
      bad++; $display("FAIL mispredict_ctrl: got %b, required 00011", ctrl_obs());
    end
    tick();
    total++;
    if (perfMispredicts !== 4'd1 || perfLoadUse !== 4'd0 || perfStallCycles !== 4'd0) begin
      bad++; $display("FAIL mispredict_count: mis=%0d lu=%0d stall=%0d, required 1 0 0",
                      perfMispredicts, perfLoadUse, perfStallCycles);
    end
  endtask

  task automatic test_mem_wait_mispredict();
    do_reset();
    exValid = 1; exIsBranch = 1; exBranchTaken = 1; exBranchPredicted = 0;
    memReq = 1; memReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ctrl_obs() !== 5'b11100) begin
        bad++; $display("FAIL memwait_stall[%0d]: got %b, required 11100", i, ctrl_obs());
      end
      tick();
    end
    memReady = 1;
    #1;
    total++;
    if (ctrl_obs() !== 5'b00011 || ctrlState !== 2'd1) begin
      bad++; $display("FAIL memwait_release: ctrl=%b state=%0d, required 00011 1", ctrl_obs(), ctrlState);
    end
    tick();
    total++;
    if (perfMispredicts !== 4'd1 || perfStallCycles !== 4'd3 || ctrlState !== 2'd0) begin
      bad++; $display("FAIL memwait_count: mis=%0d stall=%0d state=%0d, required 1 3 0",
                      perfMispredicts, perfStallCycles, ctrlState);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    memReq = 1; memReady = 0;
    tick();
    total++;
    if (ctrlState !== 2'd1 || memTimeout !== 1'b0) begin
      bad++; $display("FAIL watchdog_edge1: state=%0d tmo=%b, required 1 0", ctrlState, memTimeout);
    end
    tick(); tick();
    total++;
    if (ctrlState !== 2'd1) begin
      bad++; $display("FAIL watchdog_edge3: state=%0d, required 1", ctrlState);
    end
    tick();
    total++;
    if (ctrlState !== 2'd2 || memTimeout !== 1'b1) begin
      bad++; $display("FAIL watchdog_edge4: state=%0d tmo=%b, required 2 1", ctrlState, memTimeout);
    end
    memReady = 1;
    #1;
    total++;
    if (ctrl_obs() !== 5'b11100) begin
      bad++; $display("FAIL watchdog_sticky_ctrl: got %b, required 11100", ctrl_obs());
    end
    memReq = 0;
    tick();
    total++;
    if (ctrlState !== 2'd2 || ctrl_obs() !== 5'b11100 || perfStallCycles !== 4'd5) begin
      bad++; $display("FAIL watchdog_sticky: state=%0d ctrl=%b stall=%0d, required 2 11100 5",
                      ctrlState, ctrl_obs(), perfStallCycles);
    end
  endtask

  task automatic test_async_reset();
    // Entered from test_watchdog, still in ERROR, 1 time unit after an edge.
    memReq = 1;
    #2 rst = 0;
    #1;
    total++;
    if (ctrlState !== 2'd0 || memTimeout !== 1'b0 || ctrl_obs() !== 5'b0) begin
      bad++; $display("FAIL async_reset_state: state=%0d tmo=%b ctrl=%b, required 0 0 00000",
                      ctrlState, memTimeout, ctrl_obs());
    end
    total++;
    if (perfStallCycles !== '0 || perfMispredicts !== '0 || perfLoadUse !== '0) begin
      bad++; $display("FAIL async_reset_counters: stall=%0d mis=%0d lu=%0d, required 0 0 0",
                      perfStallCycles, perfMispredicts, perfLoadUse);
    end
    do_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use(5'd9);
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (perfLoadUse !== 4'd15 || perfStallCycles !== 4'd15) begin
      bad++; $display("FAIL saturation: lu=%0d stall=%0d, required 15 15", perfLoadUse, perfStallCycles);
    end
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int cyc = 0; cyc < 50; cyc++) begin
        exValid           = ($urandom_range(0, 3) != 0);
        exIsBranch        = 1'($urandom);
        exBranchTaken     = 1'($urandom);
        exBranchPredicted = 1'($urandom);
        exIsLoad          = 1'($urandom);
        exRdWriteEnable   = ($urandom_range(0, 3) != 0);
        exRdAddr          = RAW'($urandom_range(0, 3));
        idValid           = ($urandom_range(0, 3) != 0);
        idRs1Used         = 1'($urandom);
        idRs2Used         = 1'($urandom);
        idRs1Addr         = RAW'($urandom_range(0, 3));
        idRs2Addr         = RAW'($urandom_range(0, 3));
        memReq            = ($urandom_range(0, 3) == 0) || (blk == 5 && cyc > 30);
        memReady          = (blk == 5 && cyc > 30) ? 1'b0 : 1'($urandom);
        #1;
        total++;
        if (ctrl_obs() !== mdl_ctrl() || ctrlState !== mdl_state() || memTimeout !== m_err) begin
          bad++;
          $display("FAIL random_ctrl blk%0d cyc%0d: ctrl=%b state=%0d tmo=%b, required ctrl=%b state=%0d tmo=%b",
                   blk, cyc, ctrl_obs(), ctrlState, memTimeout, mdl_ctrl(), mdl_state(), m_err);
        end
        total++;
        if (perfStallCycles !== PCW'(m_stall) || perfMispredicts !== PCW'(m_mis) || perfLoadUse !== PCW'(m_lu)) begin
          bad++;
          $display("FAIL random_counters blk%0d cyc%0d: stall=%0d mis=%0d lu=%0d, required %0d %0d %0d",
                   blk, cyc, perfStallCycles, perfMispredicts, perfLoadUse, m_stall, m_mis, m_lu);
        end
        tick();
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    model_clear();
    test_reset();
    test_load_use();
    test_mispredict();
    test_mem_wait_mispredict();
    test_watchdog();
    test_async_reset();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter PERF_CNT_WIDTH, default 32, performance counter width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum consecutive memory-wait cycles (legal range 2..255).
REQ-004 SHALL have port clk, in, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, in, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port exValid, in, 1, EX holds a valid instruction.
REQ-007 SHALL have ports exIsBranch, exBranchTaken and exBranchPredicted, each in, 1: branch in EX, actual outcome, predicted outcome.
REQ-008 SHALL have ports exIsLoad and exRdWriteEnable, each in, 1, plus exRdAddr, in, REG_ADDR_WIDTH: EX load and destination.
REQ-009 SHALL have ports idValid, idRs1Used and idRs2Used, each in, 1, plus idRs1Addr and idRs2Addr, each in, REG_ADDR_WIDTH: ID source operands.
REQ-010 SHALL have ports memReq and memReady, each in, 1: MEM data access issued, and access complete this cycle.
REQ-011 SHALL have ports ifStall, idStall and exStall, each out, 1: hold the corresponding pipeline register.
REQ-012 SHALL have ports idFlush and exFlush, each out, 1: squash IF/ID, and insert a bubble into ID/EX.
REQ-013 SHALL have port ctrlState, out, 2, FSM state: RUN=0, MEM_WAIT=1, ERROR=2.
REQ-014 SHALL have port memTimeout, out, 1, sticky watchdog error.
REQ-015 SHALL have ports perfStallCycles, perfMispredicts and perfLoadUse, each out, PERF_CNT_WIDTH.

Function
REQ-016 SHALL define memWait = memReq & !memReady.
REQ-017 SHALL define stallAll = memWait | (ctrlState==ERROR).
REQ-018 SHALL define mispredict = exValid & exIsBranch & (exBranchTaken != exBranchPredicted).
REQ-019 SHALL define loadUse = exValid & exIsLoad & exRdWriteEnable & (exRdAddr!=0) & idValid & ((idRs1Used & idRs1Addr==exRdAddr) | (idRs2Used & idRs2Addr==exRdAddr)).
REQ-020 SHALL apply priority stallAll > mispredict > loadUse; all outputs combinational from inputs and state, zero latency.
REQ-021 SHALL, on stallAll: ifStall=idStall=exStall=1, idFlush=exFlush=0.
REQ-022 SHALL, on mispredict without stallAll: idFlush=exFlush=1 and all stalls 0.
REQ-023 SHALL, on loadUse without stallAll or mispredict: ifStall=idStall=1, exFlush=1, exStall=0, idFlush=0.
REQ-024 SHALL, otherwise, drive all stall and flush outputs 0.
REQ-025 SHALL transition RUN->MEM_WAIT when memWait holds.
REQ-026 SHALL transition MEM_WAIT->RUN when memReady=1, or when memReq=0 (request dropped).
REQ-027 SHALL transition to ERROR when memWait holds and waitCount==TIMEOUT-1.
REQ-028 SHALL keep ERROR sticky until reset.
REQ-029 SHALL keep an internal waitCount (8 bits) that increments on every memWait cycle and clears on any non-memWait cycle.
REQ-030 SHALL drive memTimeout=1 exactly when ctrlState==ERROR.
REQ-031 SHALL increment perfStallCycles on every cycle with stallAll or the REQ-023 stall.
REQ-032 SHALL increment perfMispredicts on each cycle where the REQ-022 action is taken; a mispredict held under stallAll counts once, when released.
REQ-033 SHALL increment perfLoadUse on each cycle where the REQ-023 action is taken.
REQ-034 SHALL saturate all counters at all-ones, with no wrap.

Reset
REQ-035 SHALL, while rst=0: ctrlState=RUN, waitCount=0, memTimeout=0, all perf counters 0, all stall and flush outputs 0, irrespective of inputs.
REQ-036 SHALL, on reset deassertion, start in RUN with evaluation per REQ-020 from the first clock edge.
REQ-037 SHALL, on reset asserted mid-MEM_WAIT or in ERROR, return immediately to RUN with counters cleared.

Verification
REQ-038 SHALL cover load-use: exIsLoad=1, exRdWriteEnable=1, exRdAddr=5, idRs2Used=1, idRs2Addr=5 -> ifStall=idStall=exFlush=1, exStall=0, perfLoadUse 0->1; same with exRdAddr=0 -> no stall.
REQ-039 SHALL cover mispredict: exIsBranch=1, taken=1, predicted=0, plus a simultaneous loadUse -> idFlush=exFlush=1, all stalls 0, perfMispredicts=1, perfLoadUse unchanged.
REQ-040 SHALL cover mispredict under memory wait: memReq=1, memReady=0 for 3 cycles, then memReady=1 -> 3 cycles all-stall with no flush, flush on the release cycle only, perfMispredicts=1, perfStallCycles=3.
REQ-041 SHALL cover the watchdog: TIMEOUT=4, memReq=1, memReady=0 held -> ctrlState=1 after edge 1, ctrlState=2 and memTimeout=1 after edge 4, stalls stay 1 even after memReady=1.
REQ-042 SHALL cover reset: rst=0 asynchronously while in ERROR -> memTimeout, ctrlState and counters 0 without a clock edge.
REQ-043 SHALL cover saturation: PERF_CNT_WIDTH=4 with 20 load-use cycles -> perfLoadUse=15.
